// File: rtl/counter_update_merger_pkg.sv
// Shared defaults and the snapshot record type for the counter update merger.
package counter_merge_pkg;

    localparam int DEF_WIDTH  = 4;
    localparam int DEF_STEP_A = 1;
    localparam int DEF_STEP_B = 2;
    localparam int DEF_DEPTH  = 4;

    typedef struct packed {
        logic                 wrap;
        logic [DEF_WIDTH-1:0] data;
    } snap_t;

endpackage

// File: rtl/counter_update_merger_if.sv
// Request handshakes, live count and snapshot stream of the counter update merger.
interface counter_update_merger_if #(
    parameter int WIDTH = counter_merge_pkg::DEF_WIDTH
);
    logic             a_valid;
    logic             a_ready;
    logic             b_valid;
    logic             b_ready;
    logic [WIDTH-1:0] count;
    logic             snap_valid;
    logic             snap_ready;
    logic [WIDTH-1:0] snap_data;
    logic             snap_wrap;

    modport master (
        output a_valid, b_valid, snap_ready,
        input  a_ready, b_ready, count, snap_valid, snap_data, snap_wrap
    );

    modport slave (
        input  a_valid, b_valid, snap_ready,
        output a_ready, b_ready, count, snap_valid, snap_data, snap_wrap
    );
endinterface

// File: rtl/counter_update_merger_snap_fifo.sv
// Circular snapshot buffer with an occupancy counter; head entry is read without bypass.
module snap_fifo #(
    parameter int DEPTH = counter_merge_pkg::DEF_DEPTH,
    parameter int DW    = counter_merge_pkg::DEF_WIDTH + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic [DW-1:0] o_data,
    output logic          o_full,
    output logic          o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_occ;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_occ == (AW+1)'(DEPTH));
    assign o_empty = (r_occ == {(AW+1){1'b0}});
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_data  = r_mem[r_rd_ptr];

    // Storage array; contents need no reset because occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_occ    <= {(AW+1){1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + (AW+1)'(1);
                2'b01:   r_occ <= r_occ - (AW+1)'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end
endmodule

// File: rtl/counter_update_merger.sv
// Merges two increment sources into one counter update per cycle and logs each result.
module counter_update_merger
    import counter_merge_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STEP_A = DEF_STEP_A,
    parameter int STEP_B = DEF_STEP_B,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    counter_update_merger_if.slave  bus
);
    logic [WIDTH-1:0] r_count;
    logic [WIDTH:0]   w_inc;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_ready;
    logic             w_fire_a;
    logic             w_fire_b;
    logic             w_push;
    logic             w_pop;

    // Ready comes only from registered occupancy and reset, never from the requesters.
    assign w_ready  = rst_n & ~w_full;
    assign w_fire_a = bus.a_valid & w_ready;
    assign w_fire_b = bus.b_valid & w_ready;
    assign w_push   = w_fire_a | w_fire_b;
    assign w_pop    = bus.snap_ready & ~w_empty;
    assign w_sum    = {1'b0, r_count} + w_inc;

    // Combined step for this cycle; both sources together still make one update.
    always_comb begin
        w_inc = {(WIDTH+1){1'b0}};
        case ({w_fire_a, w_fire_b})
            2'b10:   w_inc = (WIDTH+1)'(STEP_A);
            2'b01:   w_inc = (WIDTH+1)'(STEP_B);
            2'b11:   w_inc = (WIDTH+1)'(STEP_A + STEP_B);
            default: w_inc = {(WIDTH+1){1'b0}};
        endcase
    end

    // Sole writer of the counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= {WIDTH{1'b0}};
        end else if (w_push) begin
            r_count <= w_sum[WIDTH-1:0];
        end else begin
            r_count <= r_count;
        end
    end

    snap_fifo #(
        .DEPTH (DEPTH),
        .DW    (WIDTH + 1)
    ) u_snap_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_sum),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign bus.a_ready    = w_ready;
    assign bus.b_ready    = w_ready;
    assign bus.count      = r_count;
    assign bus.snap_valid = ~w_empty;
    assign bus.snap_data  = w_head[WIDTH-1:0];
    assign bus.snap_wrap  = w_head[WIDTH];
endmodule

// File: tb/tb_counter_update_merger.sv
// Directed bench: expected snapshots are queued at issue time and checked by a stream monitor.
module tb_counter_update_merger;
    import counter_merge_pkg::*;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    snap_t exp_q[$];

    counter_update_merger_if #(.WIDTH(DEF_WIDTH)) bus ();

    counter_update_merger dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request cycle; the expected snapshot is hand-supplied.
    task automatic fire(input logic a, input logic b, input logic ew, input logic [3:0] ed);
        snap_t s;
        check("ready_before_fire", int'(bus.a_ready & bus.b_ready), 1);
        s.wrap = ew;
        s.data = ed;
        exp_q.push_back(s);
        bus.a_valid = a;
        bus.b_valid = b;
        tick();
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
    endtask

    // Monitor: pop the expected queue whenever a snapshot is consumed.
    initial begin
        snap_t s;
        forever begin
            @(negedge clk);
            if (rst_n && bus.snap_valid && bus.snap_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_snapshot: got data %0d wrap %0d expected none",
                             bus.snap_data, bus.snap_wrap);
                end else begin
                    s = exp_q.pop_front();
                    check("snap_data", int'(bus.snap_data), int'(s.data));
                    check("snap_wrap", int'(bus.snap_wrap), int'(s.wrap));
                end
            end
        end
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        bus.snap_ready = 1'b1;

        tick();
        tick();
        check("reset_count", int'(bus.count), 0);
        check("reset_snap_valid", int'(bus.snap_valid), 0);
        check("reset_a_ready", int'(bus.a_ready), 0);
        check("reset_b_ready", int'(bus.b_ready), 0);
        rst_n = 1'b1;
        tick();
        check("idle_count", int'(bus.count), 0);
        check("idle_snap_valid", int'(bus.snap_valid), 0);
        check("idle_a_ready", int'(bus.a_ready), 1);
        check("idle_b_ready", int'(bus.b_ready), 1);

        fire(1'b1, 1'b0, 1'b0, 4'd1);
        fire(1'b1, 1'b0, 1'b0, 4'd2);
        fire(1'b1, 1'b0, 1'b0, 4'd3);
        check("count_after_a", int'(bus.count), 3);

        fire(1'b0, 1'b1, 1'b0, 4'd5);
        check("count_at_5", int'(bus.count), 5);
        fire(1'b1, 1'b1, 1'b0, 4'd8);
        check("count_after_both", int'(bus.count), 8);
        tick();
        check("single_snap_drained", exp_q.size(), 0);

        fire(1'b0, 1'b1, 1'b0, 4'd10);
        fire(1'b0, 1'b1, 1'b0, 4'd12);
        fire(1'b0, 1'b1, 1'b0, 4'd14);
        check("count_at_14", int'(bus.count), 14);
        fire(1'b1, 1'b1, 1'b1, 4'd1);
        check("count_after_wrap", int'(bus.count), 1);
        tick();

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("count_cleared", int'(bus.count), 0);

        // Backpressure: four pushes fill the buffer, the next two are refused.
        bus.snap_ready = 1'b0;
        bus.a_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            snap_t s;
            check("bp_a_ready", int'(bus.a_ready), (i < 4) ? 1 : 0);
            if (i < 4) begin
                s.wrap = 1'b0;
                s.data = 4'(i + 1);
                exp_q.push_back(s);
            end
            tick();
        end
        bus.a_valid = 1'b0;
        check("bp_count_hold", int'(bus.count), 4);
        check("bp_a_ready_low", int'(bus.a_ready), 0);
        check("bp_b_ready_low", int'(bus.b_ready), 0);
        check("bp_head_stable", int'(bus.snap_data), 1);
        check("bp_head_valid", int'(bus.snap_valid), 1);
        bus.snap_ready = 1'b1;
        tick();
        bus.snap_ready = 1'b0;
        check("bp_ready_after_pop", int'(bus.a_ready), 1);
        check("bp_entries_left", exp_q.size(), 3);
        check("bp_head_next", int'(bus.snap_data), 2);

        rst_n = 1'b0;
        exp_q.delete();
        tick();
        check("midrst_snap_valid", int'(bus.snap_valid), 0);
        check("midrst_count", int'(bus.count), 0);
        rst_n = 1'b1;
        bus.snap_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("post_rst_no_snap", int'(bus.snap_valid), 0);
        fire(1'b1, 1'b0, 1'b0, 4'd1);

        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() != 0) tick();
        end
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/counter_update_merger.md
# counter_update_merger

Race-free counter stage that accepts increment requests from two independent sources and applies both in a single update each clock, including the case where both arrive in the same cycle. It sits upstream of the counter monitor/display logic. Each applied update pushes a snapshot of the new count value into a small output buffer. The buffer drains over a valid/ready stream, so the downstream monitor sees every intermediate value in order, with no lost or duplicated updates.

## Interface
Parameters:
- WIDTH, 4, counter and snapshot data width
- STEP_A, 1, increment applied by a source-A request
- STEP_B, 2, increment applied by a source-B request
- DEPTH, 4, snapshot buffer entries; power of two, ≥2

Ports:
- clk  in  1  single clock; all state updates on posedge clk
- rst_n  in  1  reset, synchronous and active-low
- a_valid  in  1  source-A increment request
- a_ready  out  1  source-A request accepted when a_valid & a_ready
- b_valid  in  1  source-B increment request
- b_ready  out  1  source-B request accepted when b_valid & b_ready
- count  out  WIDTH  current registered counter value
- snap_valid  out  1  snapshot available at buffer head
- snap_ready  in  1  downstream consumes head when snap_valid & snap_ready
- snap_data  out  WIDTH  counter value after the update
- snap_wrap  out  1  that update carried out of WIDTH bits

## Operation
- Reset (rst_n=0 at posedge):
  - count=0.
  - Buffer emptied, pointers=0.
  - snap_valid=0.
  - a_ready=b_ready=0 while rst_n is low.
- Acceptance gating: a_ready = b_ready = rst_n & ~full. Both sources are gated by buffer space only; there is no arbitration between them.
- Per cycle, define fa = a_valid&a_ready and fb = b_valid&b_ready. Increment inc:
  - fa only: STEP_A.
  - fb only: STEP_B.
  - Both: STEP_A+STEP_B.
  - Neither: no update and no push.
- Update arithmetic: sum = count + inc, computed at WIDTH+1 bits.
  - count ← sum[WIDTH-1:0].
  - Push {snap_wrap=sum[WIDTH], snap_data=sum[WIDTH-1:0]}.
  - A simultaneous fa&fb produces exactly one update and exactly one snapshot.
- Counter state is written from exactly one sequential process. No blocking-assignment sharing across processes.
- Buffer behaviour:
  - Circular, DEPTH entries; rd/wr pointers wrap modulo DEPTH.
  - An occupancy counter of width clog2(DEPTH)+1 tracks fill.
  - full when occupancy==DEPTH; empty when occupancy==0.
  - snap_valid = ~empty. snap_data/snap_wrap present the head entry and hold stable while snap_valid & ~snap_ready.
- Simultaneous push and pop:
  - Not full: occupancy unchanged and both pointers advance.
  - Full: ready is low, so no push can occur; the pop frees one slot and ready rises the next cycle.
  - Empty: a pop is impossible (snap_valid=0). The pushed entry becomes visible the next cycle; there is no bypass.
- Reset mid-operation: all pending snapshots are discarded. The count returns to 0 regardless of in-flight requests.

## Timing
- Request accepted at edge N: count shows the new value after edge N, and snap_valid=1 after edge N when the buffer was empty. Request-to-snapshot latency is 1 cycle.
- Sustained throughput: one update per cycle while snap_ready stays high.
- With snap_ready low, ready falls in the cycle after the DEPTH-th push.
- Ready depends only on registered state and rst_n. There is no combinational path from a_valid/b_valid/snap_ready to a_ready/b_ready.

## Structure
- Package counter_merge_pkg holds:
  - Default WIDTH, STEP_A and STEP_B constants.
  - typedef snap_t {logic wrap; logic [WIDTH-1:0] data}.
- One sub-module, snap_fifo: synchronous FIFO with parameters DEPTH and data width WIDTH+1, a push/pop interface, and full/empty outputs.
- The top level contains the fire logic, the adder and the count register, and instantiates snap_fifo.

## Test plan
- Reset then idle: rst_n low for 2 cycles, then high.
  - count=0, snap_valid=0, a_ready=b_ready=1 one cycle after release.
- A only: a_valid pulsed 3 cycles with snap_ready=1.
  - Snapshots 1, 2, 3, each with wrap=0.
  - count=3.
- Simultaneous requests: a_valid=b_valid=1 for one cycle from count=5.
  - Exactly one snapshot, value 8.
  - count=8.
- Wrap: from count=14, fire A and B together.
  - Snapshot data=1, wrap=1.
  - count=1.
- Backpressure: snap_ready=0, fire A for 6 cycles.
  - 4 snapshots accepted (1..4), then a_ready=0 and count holds at 4.
  - Raise snap_ready for one cycle: head=1 pops, and a_ready=1 the next cycle.
- Reset mid-stream: with 3 entries buffered, assert rst_n=0 for one edge.
  - snap_valid=0 and count=0 after that edge.
  - No stale snapshot appears after release.
